// File: rtl/addsub_pkg.sv
// Shared state encoding, operation codes and a constant log2 helper
// for the serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, chained to form each processing slice.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock through a
// ripple slice, carry held in a register, start/done handshake.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
  localparam int CW     = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_t state_reg, state_next;
  logic   load, run, last;

  logic [WIDTH-1:0]          a_sh_reg, b_sh_reg, res_reg, res_next;
  logic [WIDTH-1:0]          sum_reg;
  logic                      carry_reg, carry_out_reg, ovf_reg;
  logic [CW-1:0]             cnt_reg;
  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic                      slice_cout, msb_cin;

  // Ripple chain: each cell's carry-in comes from the previous generate block.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_fa
    logic cin, cout, s;
    if (gi == 0) begin : g_first
      assign cin = carry_reg;
    end else begin : g_next
      assign cin = g_fa[gi-1].cout;
    end
    full_adder u_fa (
      .A    (a_sh_reg[gi]),
      .B    (b_sh_reg[gi]),
      .Cin  (cin),
      .Sum  (s),
      .Cout (cout)
    );
    assign slice_sum[gi] = s;
  end

  assign slice_cout = g_fa[BITS_PER_CYCLE-1].cout;
  assign msb_cin    = g_fa[BITS_PER_CYCLE-1].cin;
  assign res_next   = (res_reg >> BITS_PER_CYCLE) |
                      (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    run        = 1'b0;
    last       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        run  = 1'b1;
        last = (cnt_reg == LAST);
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_reg       <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else if (load) begin
      // Subtraction as A + ~B + 1: the +1 enters through the carry register.
      a_sh_reg  <= A;
      b_sh_reg  <= (sub == OP_SUB) ? ~B : B;
      carry_reg <= (sub == OP_SUB);
      cnt_reg   <= '0;
    end else if (run) begin
      a_sh_reg  <= a_sh_reg >> BITS_PER_CYCLE;
      b_sh_reg  <= b_sh_reg >> BITS_PER_CYCLE;
      res_reg   <= res_next;
      carry_reg <= slice_cout;
      cnt_reg   <= cnt_reg + 1'b1;
      if (last) begin
        sum_reg       <= res_next;
        carry_out_reg <= slice_cout;
        ovf_reg       <= slice_cout ^ msb_cin;
      end
    end
  end

  assign busy     = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);
  assign Sum      = sum_reg;
  assign Carry    = carry_out_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH=8 for
// BITS_PER_CYCLE 1 (main instance) and 2/4/8 (side instances).
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, carry, ovf;
  logic [7:0] sum;

  logic       start_w [3];
  logic       sub_w = 1'b0;
  logic [7:0] a_w = '0, b_w = '0;
  logic       busy_w [3];
  logic       done_w [3];
  logic       carry_w [3];
  logic       ovf_w [3];
  logic [7:0] sum_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(a), .B(b),
    .busy(busy), .done(done), .Sum(sum), .Carry(carry), .Overflow(ovf)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_wide
    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(2 << gi)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_w[gi]), .sub(sub_w), .A(a_w), .B(b_w),
      .busy(busy_w[gi]), .done(done_w[gi]), .Sum(sum_w[gi]),
      .Carry(carry_w[gi]), .Overflow(ovf_w[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, carry, sum} of x + y or x - y.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] yy;
    logic [8:0] t;
    logic       v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {8'd0, s};
    v  = (x[7] == yy[7]) && (t[7] != x[7]);
    return {v, t[8], t[7:0]};
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [7:0] es, input logic ec, input logic ev, input string tag);
    int nb;
    a = x; b = y; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    while (busy && nb < 64) begin
      nb++;
      tick();
    end
    check({tag, "_busy"}, nb, 8);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_carry"}, carry, ec);
    check({tag, "_ovf"}, ovf, ev);
    $display("op %s bpc=1: %02h %s %02h -> sum=%02h c=%0d v=%0d", tag, x, s ? "-" : "+", y, sum, carry, ovf);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_w(input int idx, input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [7:0] es, input logic ec, input logic ev, input string tag);
    int nb;
    a_w = x; b_w = y; sub_w = s; start_w[idx] = 1'b1;
    tick();
    start_w[idx] = 1'b0;
    nb = 0;
    while (busy_w[idx] && nb < 64) begin
      nb++;
      tick();
    end
    check({tag, "_busy"}, nb, 8 >> (idx + 1));
    check({tag, "_done"}, done_w[idx], 1);
    check({tag, "_sum"}, sum_w[idx], es);
    check({tag, "_carry"}, carry_w[idx], ec);
    check({tag, "_ovf"}, ovf_w[idx], ev);
    $display("op %s bpc=%0d: %02h %s %02h -> sum=%02h c=%0d v=%0d", tag, 2 << idx, x, s ? "-" : "+", y,
             sum_w[idx], carry_w[idx], ovf_w[idx]);
    tick();
    check({tag, "_done_pulse"}, done_w[idx], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         n, ndone;
    logic [7:0] rx, ry;
    logic       rs;
    logic [9:0] m;

    for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sum_w4", sum_w[1], 0);
    rst_n = 1'b1;
    tick();

    // Add and subtract directed vectors
    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    do_op(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, "sub_33_33");

    // Start pulse and operand changes during RUN are ignored
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'h01; b = 8'h01;
    tick();
    start = 1'b0; a = 8'hFF; b = 8'hAA; sub = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      tick();
    end
    check("midrun_done_count", ndone, 1);
    check("midrun_sum", sum, 8'h30);
    check("midrun_carry", carry, 0);
    $display("op midrun bpc=1: 10 + 20 -> sum=%02h dones=%0d", sum, ndone);

    // Asynchronous reset in the 4th RUN cycle
    a = 8'h55; b = 8'h22; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_sum", sum, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_carry", carry, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      tick();
    end
    check("arst_no_done", ndone, 0);
    $display("op arst bpc=1: aborted, dones=%0d", ndone);
    do_op(8'h3C, 8'h44, 1'b0, 8'h80, 1'b0, 1'b1, "after_rst");

    // Back-to-back: start held through the DONE cycle
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    tick();
    a = 8'h70; b = 8'h20;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check("b2b_done1", done, 1);
    check("b2b_sum1", sum, 8'h46);
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00;
    check("b2b_no_idle", busy, 1);
    n = 1;
    while (!done && n < 50) begin
      check("b2b_sum_hold", sum, 8'h46);
      tick();
      n++;
    end
    check("b2b_spacing", n, 9);
    check("b2b_sum2", sum, 8'h90);
    check("b2b_carry2", carry, 0);
    check("b2b_ovf2", ovf, 1);
    $display("op b2b bpc=1: 12+34 then 70+20 -> sum=%02h spacing=%0d", sum, n);
    tick();

    // Wider slices
    run_w(1, 8'h9C, 8'h6A, 1'b0, 8'h06, 1'b1, 1'b0, "w4_9c_6a");
    run_w(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "w2_80_01");
    run_w(2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "w8_7f_01");

    // Random comparisons against the reference
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
      m = model(rx, ry, rs);
      do_op(rx, ry, rs, m[7:0], m[8], m[9], "rnd1");
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
        m = model(rx, ry, rs);
        run_w(k, rx, ry, rs, m[7:0], m[8], m[9], "rndw");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
